// File: rtl/quad_encoder_gen.sv
// Quadrature encoder emulator: emits a commanded number of Gray-code steps on enc_a/enc_b,
// holding each state PHASE_CYCLES clocks, then settles before signalling done.
module quad_encoder_gen #(
   parameter int unsigned PHASE_CYCLES = 16,
   parameter int unsigned COUNT_W      = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic               cmd_dir,
   input  logic [COUNT_W-1:0] cmd_steps,
   input  logic               abort,
   output logic               enc_a,
   output logic               enc_b,
   output logic               busy,
   output logic               done,
   output logic [COUNT_W-1:0] position
);

   localparam int unsigned TIMER_W = (PHASE_CYCLES > 2) ? $clog2(PHASE_CYCLES) : 1;
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(PHASE_CYCLES - 1);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] RUN    = 2'd1;
   localparam logic [1:0] SETTLE = 2'd2;
   localparam logic [1:0] DONE   = 2'd3;

   logic [1:0]         state_q, state_d;
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic [COUNT_W-1:0] remaining_q, remaining_d;
   logic [COUNT_W-1:0] pos_q, pos_d;
   logic               dir_q, dir_d;
   logic               enc_a_q, enc_a_d;
   logic               enc_b_q, enc_b_d;
   logic               timer_wrap;

   assign timer_wrap = (timer_q == TIMER_LAST);

   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      remaining_d = remaining_q;
      pos_d       = pos_q;
      dir_d       = dir_q;
      enc_a_d     = enc_a_q;
      enc_b_d     = enc_b_q;

      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               dir_d       = cmd_dir;
               remaining_d = cmd_steps;
               timer_d     = '0;
               state_d     = (cmd_steps == '0) ? DONE : RUN;
            end
         end

         RUN: begin
            if (abort) begin
               // Abort wins over a transition scheduled on the same edge.
               timer_d = '0;
               state_d = DONE;
            end else if (timer_wrap) begin
               timer_d     = '0;
               remaining_d = remaining_q - COUNT_W'(1);
               // Up: 00->10->11->01; down is the reverse. One bit flips per step.
               if (dir_q) begin
                  enc_a_d = ~enc_b_q;
                  enc_b_d = enc_a_q;
                  pos_d   = pos_q + COUNT_W'(1);
               end else begin
                  enc_a_d = enc_b_q;
                  enc_b_d = ~enc_a_q;
                  pos_d   = pos_q - COUNT_W'(1);
               end
               if (remaining_q == COUNT_W'(1)) begin
                  state_d = SETTLE;
               end
            end else begin
               timer_d = timer_q + TIMER_W'(1);
            end
         end

         SETTLE: begin
            if (abort || timer_wrap) begin
               timer_d = '0;
               state_d = DONE;
            end else begin
               timer_d = timer_q + TIMER_W'(1);
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         timer_q     <= '0;
         remaining_q <= '0;
         pos_q       <= '0;
         dir_q       <= 1'b0;
         enc_a_q     <= 1'b0;
         enc_b_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         remaining_q <= remaining_d;
         pos_q       <= pos_d;
         dir_q       <= dir_d;
         enc_a_q     <= enc_a_d;
         enc_b_q     <= enc_b_d;
      end
   end

   assign cmd_ready = (state_q == IDLE);
   assign busy      = (state_q == RUN) || (state_q == SETTLE);
   assign done      = (state_q == DONE);
   assign enc_a     = enc_a_q;
   assign enc_b     = enc_b_q;
   assign position  = pos_q;

   a_one_bit_step: assert property (@(posedge clk) disable iff (!rst_n)
      $countones({enc_a_d, enc_b_d} ^ {enc_a_q, enc_b_q}) <= 1);

   a_run_has_work: assert property (@(posedge clk) disable iff (!rst_n)
      (state_q == RUN) |-> (remaining_q != '0));

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Bench for quad_encoder_gen: schedule-based reference model checked every cycle,
// plus directed literal checks on the key points of each scenario.
module tb_quad_encoder_gen;

   localparam int PC = 4;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cmd_valid;
   logic          cmd_ready;
   logic          cmd_dir;
   logic [CW-1:0] cmd_steps;
   logic          abort;
   logic          enc_a;
   logic          enc_b;
   logic          busy;
   logic          done;
   logic [CW-1:0] position;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   // Model: one command record; outputs derived from elapsed cycles since accept.
   int       m_t0 = 0;
   int       m_n = 0;
   int       m_end = -10;
   int       m_base_ph = 0;
   int       m_base_pos = 0;
   logic     m_dir = 1'b0;
   logic     m_aborted = 1'b0;

   quad_encoder_gen #(
      .PHASE_CYCLES(PC),
      .COUNT_W     (CW)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_dir  (cmd_dir),
      .cmd_steps(cmd_steps),
      .abort    (abort),
      .enc_a    (enc_a),
      .enc_b    (enc_b),
      .busy     (busy),
      .done     (done),
      .position (position)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   function automatic int emitted_at(input int t);
      int lim;
      int e;
      if (m_n == 0 || t < m_t0) return 0;
      lim = t;
      if (m_aborted && lim >= m_end) lim = m_end - 1;
      e = (lim - m_t0) / PC;
      if (e > m_n) e = m_n;
      if (e < 0) e = 0;
      return e;
   endfunction

   function automatic int exp_idx(input int t);
      int e;
      e = emitted_at(t);
      return (((m_base_ph + (m_dir ? e : -e)) % 4) + 4) % 4;
   endfunction

   function automatic int exp_pos(input int t);
      int e;
      e = emitted_at(t);
      return ((m_base_pos + (m_dir ? e : -e)) % 256 + 256) % 256;
   endfunction

   function automatic int phase_ab(input int idx);
      case (idx)
         0:       return 0;  // 00
         1:       return 2;  // 10
         2:       return 3;  // 11
         default: return 1;  // 01
      endcase
   endfunction

   always @(posedge clk) begin
      int ph;
      int p;
      #1;
      cyc++;
      if (!rst_n) begin
         m_n        = 0;
         m_t0       = 0;
         m_end      = -10;
         m_base_ph  = 0;
         m_base_pos = 0;
         m_dir      = 1'b0;
         m_aborted  = 1'b0;
      end else if ((cyc - 1) > m_end && cmd_valid) begin
         ph         = exp_idx(cyc - 1);
         p          = exp_pos(cyc - 1);
         m_base_ph  = ph;
         m_base_pos = p;
         m_t0       = cyc;
         m_n        = int'(cmd_steps);
         m_dir      = cmd_dir;
         m_aborted  = 1'b0;
         m_end      = (m_n == 0) ? cyc : cyc + (m_n + 1) * PC;
      end else if (abort && m_n > 0 && (cyc - 1) >= m_t0 && (cyc - 1) < m_end) begin
         m_aborted = 1'b1;
         m_end     = cyc;
      end
      check("enc_ab", int'({enc_a, enc_b}), phase_ab(exp_idx(cyc)));
      check("position", int'(position), exp_pos(cyc));
      check("busy", int'(busy), int'(m_n > 0 && cyc >= m_t0 && cyc < m_end));
      check("done", int'(done), int'(cyc == m_end));
      check("cmd_ready", int'(cmd_ready), int'(cyc > m_end));
   end

   task automatic skip(input int k);
      repeat (k) @(posedge clk);
      #2;
   endtask

   task automatic wait_idle();
      int guard = 0;
      @(negedge clk);
      while (!cmd_ready && guard < 3000) begin
         @(negedge clk);
         guard++;
      end
      if (!cmd_ready) check("idle_timeout", 0, 1);
   endtask

   // Returns 2 time units after the accept edge T0.
   task automatic send(input logic dir, input int steps);
      int guard = 0;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_dir   = dir;
      cmd_steps = CW'(steps);
      while (!cmd_ready && guard < 3000) begin
         @(negedge clk);
         guard++;
      end
      if (!cmd_ready) check("accept_timeout", 0, 1);
      @(posedge clk);
      #2;
      cmd_valid = 1'b0;
      cmd_dir   = ~dir;
      cmd_steps = 8'hA5;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_dir   = 1'b0;
      cmd_steps = '0;
      abort     = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check("rst_ab", int'({enc_a, enc_b}), 0);
      check("rst_ready", int'(cmd_ready), 1);
      @(negedge clk);
      rst_n = 1'b1;

      // Up 4 steps from 00.
      send(1'b1, 4);
      skip(4);  check("up_ab1", int'({enc_a, enc_b}), 2);
      skip(4);  check("up_ab2", int'({enc_a, enc_b}), 3);
      skip(4);  check("up_ab3", int'({enc_a, enc_b}), 1);
      skip(4);  check("up_ab4", int'({enc_a, enc_b}), 0);
      check("up_pos", int'(position), 4);
      skip(3);  check("up_busy_last", int'(busy), 1);
      skip(1);  check("up_done", int'(done), 1);
      check("up_busy_off", int'(busy), 0);
      skip(1);  check("up_ready", int'(cmd_ready), 1);

      // Down 3 steps continuing from 00.
      send(1'b0, 3);
      skip(4);  check("dn_ab1", int'({enc_a, enc_b}), 1);
      wait_idle();
      check("dn_pos", int'(position), 1);
      check("dn_ab", int'({enc_a, enc_b}), 2);

      // Zero steps: immediate done, no motion.
      send(1'b1, 0);
      check("zero_done", int'(done), 1);
      check("zero_ab", int'({enc_a, enc_b}), 2);
      skip(1);  check("zero_ready", int'(cmd_ready), 1);

      // cmd_valid while busy is ignored.
      send(1'b1, 2);
      skip(1);
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_steps = 8'd50;
      cmd_dir   = 1'b0;
      repeat (2) @(negedge clk);
      cmd_valid = 1'b0;
      wait_idle();
      check("blk_pos", int'(position), 3);
      check("blk_ab", int'({enc_a, enc_b}), 1);

      // abort in IDLE is ignored.
      @(negedge clk); abort = 1'b1;
      @(negedge clk); abort = 1'b0;

      // Asynchronous reset mid-run.
      send(1'b0, 5);
      skip(6);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_ab", int'({enc_a, enc_b}), 0);
      check("arst_pos", int'(position), 0);
      check("arst_busy", int'(busy), 0);
      check("arst_done", int'(done), 0);
      check("arst_ready", int'(cmd_ready), 1);
      @(negedge clk);
      rst_n = 1'b1;

      // Position wrap down through zero and back.
      send(1'b0, 2);
      skip(4);  check("wrap_pos1", int'(position), 255);
      check("wrap_ab1", int'({enc_a, enc_b}), 1);
      skip(4);  check("wrap_pos2", int'(position), 254);
      wait_idle();
      send(1'b1, 2);
      wait_idle();
      check("wrap_back", int'(position), 0);
      check("wrap_ab", int'({enc_a, enc_b}), 0);

      // Abort after transition 2 of a 10-step run.
      send(1'b1, 10);
      skip(8);  check("ab_pos2", int'(position), 2);
      abort = 1'b1;
      skip(1);  check("ab_done", int'(done), 1);
      check("ab_pos", int'(position), 2);
      abort = 1'b0;
      skip(4);  check("ab_hold", int'({enc_a, enc_b}), 3);

      // Abort on the edge of a scheduled transition suppresses it.
      send(1'b0, 3);
      skip(3);
      abort = 1'b1;
      skip(1);  check("abx_done", int'(done), 1);
      check("abx_pos", int'(position), 2);
      check("abx_ab", int'({enc_a, enc_b}), 3);
      abort = 1'b0;

      // Maximum step count.
      send(1'b1, 255);
      wait_idle();
      check("max_pos", int'(position), 1);
      check("max_ab", int'({enc_a, enc_b}), 2);

      skip(3);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
